imul_int_mul_iter: RTL and testbench
====================================

// Module: imul_int_mul_iter
//
// PURPOSE
//   Parametrised iterative integer multiplier with latency-insensitive val/rdy streams.
//   - Computes the full 2*NBITS product of two NBITS operands using shift-add, one multiplier bit per cycle.
//   - Supports per-transaction signed/unsigned mode and optional early termination.
//   - Successor to the single-cycle multiplier; used where area matters more than throughput.
//
// PARAMETERS
//   NBITS       32  operand width; product is 2*NBITS
//   EARLY_EXIT  1   1: stop when remaining multiplier bits are all zero; 0: always NBITS iterations
//
// PORTS
//   clk                 in   1        clock; all state updates on posedge
//   reset               in   1        asynchronous, active-high reset
//   istream_val         in   1        request valid
//   istream_rdy         out  1        request ready
//   istream_msg_a       in   NBITS    multiplicand
//   istream_msg_b       in   NBITS    multiplier
//   istream_msg_signed  in   1        1: two's-complement operands; 0: unsigned
//   ostream_val         out  1        response valid
//   ostream_rdy         in   1        response ready
//   ostream_msg         out  2*NBITS  full product
//
// BEHAVIOUR
//   Reset (asynchronous, any state)
//   - state=IDLE; result, a and b registers cleared; ostream_val=0; ostream_msg=0.
//   - istream_rdy=0 while reset is high.
//   - An in-flight operation is discarded; no response is ever produced for it.
//
//   IDLE
//   - istream_rdy=1.
//   - Request fire (val&rdy) loads:
//     - a_reg = |a| zero-extended to 2*NBITS.
//     - b_reg = |b|.
//     - neg = signed & (a[msb]^b[msb]).
//     - result = 0; cnt = 0.
//     - state -> CALC.
//   - |x| is the two's-complement magnitude when signed=1, otherwise x unchanged.
//   - Magnitude of the most negative value, 2^(NBITS-1), fits in NBITS unsigned.
//
//   CALC (istream_rdy=0, ostream_val=0), each cycle:
//   - if b_reg[0]: result += a_reg.
//   - a_reg <<= 1; b_reg >>= 1; cnt++.
//   - Exit to DONE after the iteration where cnt==NBITS-1, or, when EARLY_EXIT=1, where (b_reg>>1)==0.
//   - On the exit edge, the registered result is negated (2*NBITS two's complement) if neg=1.
//   - cnt is $clog2(NBITS) bits wide.
//
//   Iteration count k
//   - EARLY_EXIT=0: k = NBITS.
//   - EARLY_EXIT=1: k = max(1, position of highest set bit of |b| + 1); |b|=0 gives k=1.
//
//   DONE
//   - ostream_val=1; istream_rdy=0; ostream_msg = result.
//   - Stable while ostream_rdy=0.
//   - Response fire -> IDLE.
//   - No request is accepted in the same cycle as the response fire.
//
//   Latency and rate
//   - Request fire at edge E0 -> ostream_val high in the cycle after edge E0+k.
//   - One operation in flight; throughput 1 per k+2 cycles.
//   - Arithmetic is modulo 2^(2*NBITS); overflow is impossible for full-width products.
//   - istream_val is ignored outside IDLE; the source holds its message until rdy.
//
// STRUCTURE
//   - imul_pkg (shared package):
//     - state enum {IDLE, CALC, DONE}.
//     - Result-mux select constants.
//     - abs/negate helper functions, reused by the divider.
//   - imul_int_mul_iter_dpath (sub-module):
//     - a/b/result/cnt/neg registers, adder, shifters, negation.
//     - Exports b_lsb, b_next_zero, cnt_last.
//   - Top level holds the FSM and drives datapath enables/selects.
//   - Line trace: inputs | state | output.
//
// TESTING
//   1. Unsigned 3*4, EARLY_EXIT=1 -> 0x0000000000000000C; ostream_val 3 cycles after E0+... (k=3).
//   2. signed=1: 0xFFFFFFFD*5 -> 0xFFFFFFFFFFFFFFF1; same operands with signed=0 -> 0x00000004FFFFFFF1.
//   3. 0x80000000*0x80000000, signed and unsigned -> 0x4000000000000000 in both modes.
//   4. b=0 -> product 0 with k=1.
//      b=0xFFFFFFFF, unsigned, a=0xFFFFFFFF -> 0xFFFFFFFE00000001 with k=32.
//      EARLY_EXIT=0 -> k=32 for every case.
//   5. ostream_rdy held low 5 cycles in DONE -> ostream_msg stable, istream_rdy=0.
//      New request is accepted only the cycle after the response fire.
//   6. reset pulsed mid-CALC:
//      - ostream_val=0 immediately, no spurious response.
//      - After release, 7*6 -> 42.
//      Random signed/unsigned stream with random val/rdy stalls checked against a golden model.

Source files
------------

// File: rtl/imul_pkg.sv
// Shared definitions for the iterative integer arithmetic units (multiplier, divider).
package imul_pkg;

    // Control FSM states shared by the iterative units
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Widest operand the helper functions handle; callers truncate to their own width
    localparam int MAX_W = 128;

    // Result register next-value select
    localparam logic [1:0] RSEL_HOLD  = 2'd0;  // keep current value
    localparam logic [1:0] RSEL_CLEAR = 2'd1;  // start of a new operation
    localparam logic [1:0] RSEL_ACC   = 2'd2;  // conditional accumulate
    localparam logic [1:0] RSEL_LAST  = 2'd3;  // final accumulate plus sign fix-up

    // Two's-complement negation; truncating the result keeps it correct at any narrower width
    function automatic logic [MAX_W-1:0] negate(input logic [MAX_W-1:0] x);
        return ~x + MAX_W'(1);
    endfunction

    // Magnitude of a value whose sign is supplied separately (is_neg = signed mode & msb)
    function automatic logic [MAX_W-1:0] abs_val(input logic [MAX_W-1:0] x, input logic is_neg);
        return is_neg ? negate(x) : x;
    endfunction

endpackage

// File: rtl/imul_int_mul_iter_dpath.sv
// Shift-add datapath: operand magnitudes, accumulator, iteration counter and sign fix-up.
module imul_int_mul_iter_dpath
    import imul_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_calc,
    input  logic [1:0]           i_rsel,
    input  logic [NBITS-1:0]     i_a,
    input  logic [NBITS-1:0]     i_b,
    input  logic                 i_signed,
    output logic                 o_b_lsb,
    output logic                 o_b_next_zero,
    output logic                 o_cnt_last,
    output logic [2*NBITS-1:0]   o_result
);

    localparam int W2 = 2 * NBITS;
    localparam int CW = (NBITS > 1) ? $clog2(NBITS) : 1;

    logic [W2-1:0]    r_a;
    logic [NBITS-1:0] r_b;
    logic [W2-1:0]    r_result;
    logic [CW-1:0]    r_cnt;
    logic             r_neg;

    logic [NBITS-1:0] w_a_mag;
    logic [NBITS-1:0] w_b_mag;
    logic [W2-1:0]    w_sum;
    logic [W2-1:0]    w_sum_fix;

    // Operand magnitudes; the most negative value maps to 2^(NBITS-1), which still fits
    assign w_a_mag = NBITS'(abs_val(MAX_W'(i_a), i_signed & i_a[NBITS-1]));
    assign w_b_mag = NBITS'(abs_val(MAX_W'(i_b), i_signed & i_b[NBITS-1]));

    // Accumulate the shifted multiplicand when the current multiplier bit is set
    always_comb begin
        w_sum     = r_b[0] ? (r_result + r_a) : r_result;
        w_sum_fix = r_neg ? W2'(negate(MAX_W'(w_sum))) : w_sum;
    end

    // Operand shift registers, counter and product sign
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_a   <= '0;
            r_b   <= '0;
            r_cnt <= '0;
            r_neg <= 1'b0;
        end else if (i_load) begin
            r_a   <= W2'(w_a_mag);
            r_b   <= w_b_mag;
            r_cnt <= '0;
            r_neg <= i_signed & (i_a[NBITS-1] ^ i_b[NBITS-1]);
        end else if (i_calc) begin
            r_a   <= r_a << 1;
            r_b   <= r_b >> 1;
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Product accumulator, negated on the final iteration when the signs differed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_result <= '0;
        end else begin
            case (i_rsel)
                RSEL_CLEAR: r_result <= '0;
                RSEL_ACC:   r_result <= w_sum;
                RSEL_LAST:  r_result <= w_sum_fix;
                default:    r_result <= r_result;
            endcase
        end
    end

    assign o_b_lsb       = r_b[0];
    assign o_b_next_zero = (r_b[NBITS-1:1] == '0);
    assign o_cnt_last    = (r_cnt == CW'(NBITS - 1));
    assign o_result      = r_result;

endmodule

// File: rtl/imul_int_mul_iter.sv
// Iterative shift-add multiplier with val/rdy request and response streams.
module imul_int_mul_iter
    import imul_pkg::*;
#(
    parameter int NBITS      = 32,
    parameter int EARLY_EXIT = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 istream_val,
    output logic                 istream_rdy,
    input  logic [NBITS-1:0]     istream_msg_a,
    input  logic [NBITS-1:0]     istream_msg_b,
    input  logic                 istream_msg_signed,
    output logic                 ostream_val,
    input  logic                 ostream_rdy,
    output logic [2*NBITS-1:0]   ostream_msg
);

    localparam logic EE = (EARLY_EXIT != 0);

    state_e     r_state;
    logic       r_istream_rdy;
    logic       r_ostream_val;

    logic       w_req_fire;
    logic       w_resp_fire;
    logic       w_exit;
    logic       w_calc;
    logic [1:0] w_rsel;
    logic       w_b_lsb;
    logic       w_b_next_zero;
    logic       w_cnt_last;

    assign w_req_fire  = istream_val & r_istream_rdy & (r_state == IDLE);
    assign w_resp_fire = r_ostream_val & ostream_rdy;
    assign w_calc      = (r_state == CALC);
    // Stop after the last bit, or as soon as the remaining multiplier bits are all zero
    assign w_exit      = w_cnt_last | (EE & w_b_next_zero);

    // Datapath result-register select
    always_comb begin
        w_rsel = RSEL_HOLD;
        if (w_req_fire)
            w_rsel = RSEL_CLEAR;
        else if (w_calc)
            w_rsel = w_exit ? RSEL_LAST : RSEL_ACC;
    end

    // Control FSM with registered handshake outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_istream_rdy <= 1'b0;
            r_ostream_val <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req_fire) begin
                        r_state       <= CALC;
                        r_istream_rdy <= 1'b0;
                    end else begin
                        r_istream_rdy <= 1'b1;
                    end
                end
                CALC: begin
                    if (w_exit) begin
                        r_state       <= DONE;
                        r_ostream_val <= 1'b1;
                    end
                end
                DONE: begin
                    // Ready rises only after the response leaves, so no same-cycle accept
                    if (w_resp_fire) begin
                        r_state       <= IDLE;
                        r_ostream_val <= 1'b0;
                        r_istream_rdy <= 1'b1;
                    end
                end
                default: begin
                    r_state       <= IDLE;
                    r_istream_rdy <= 1'b0;
                    r_ostream_val <= 1'b0;
                end
            endcase
        end
    end

    imul_int_mul_iter_dpath #(
        .NBITS (NBITS)
    ) u_dpath (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_req_fire),
        .i_calc        (w_calc),
        .i_rsel        (w_rsel),
        .i_a           (istream_msg_a),
        .i_b           (istream_msg_b),
        .i_signed      (istream_msg_signed),
        .o_b_lsb       (w_b_lsb),
        .o_b_next_zero (w_b_next_zero),
        .o_cnt_last    (w_cnt_last),
        .o_result      (ostream_msg)
    );

    assign istream_rdy = r_istream_rdy;
    assign ostream_val = r_ostream_val;

    // The multiplier LSB is consumed inside the datapath; kept visible for the line trace
    logic w_unused;
    assign w_unused = w_b_lsb;

endmodule

// File: tb/tb_imul_int_mul_iter.sv
// Self-checking bench: directed cases, stalls, reset mid-operation and a random stream.
module tb_imul_int_mul_iter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        val1 = 1'b0, val0 = 1'b0;
    logic        rdy1, rdy0, ovl1, ovl0;
    logic        ordy = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        s = 1'b0;
    logic [63:0] msg1, msg0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    imul_int_mul_iter #(.NBITS(32), .EARLY_EXIT(1)) dut (
        .clk(clk), .reset(reset),
        .istream_val(val1), .istream_rdy(rdy1),
        .istream_msg_a(a), .istream_msg_b(b), .istream_msg_signed(s),
        .ostream_val(ovl1), .ostream_rdy(ordy), .ostream_msg(msg1)
    );

    imul_int_mul_iter #(.NBITS(32), .EARLY_EXIT(0)) dut_full (
        .clk(clk), .reset(reset),
        .istream_val(val0), .istream_rdy(rdy0),
        .istream_msg_a(a), .istream_msg_b(b), .istream_msg_signed(s),
        .ostream_val(ovl0), .ostream_rdy(ordy), .ostream_msg(msg0)
    );

    // Reference product: plain wide multiplication of the interpreted operands
    function automatic logic [63:0] ref_prod(input logic [31:0] x, input logic [31:0] y, input logic sg);
        logic signed [63:0] sx, sy;
        if (sg) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Reference iteration count from the multiplier magnitude
    function automatic int ref_k(input logic [31:0] y, input logic sg, input bit ee);
        logic [31:0] m;
        int k;
        if (!ee) return 32;
        m = (sg && y[31]) ? -y : y;
        k = 1;
        for (int i = 0; i < 32; i++) if (m[i]) k = i + 1;
        return k;
    endfunction

    // Drive one request and collect its response; lat = -1 on timeout
    task automatic do_op(input bit use0, input logic [31:0] xa, input logic [31:0] xb,
                         input logic xs, output logic [63:0] prod, output int lat);
        int n;
        prod = '0;
        lat  = -1;
        a = xa; b = xb; s = xs;
        n = 0;
        while (!(use0 ? rdy0 : rdy1) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) return;
        if (use0) val0 = 1'b1; else val1 = 1'b1;
        @(posedge clk); #1;
        val0 = 1'b0; val1 = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk); #1;
            if (use0 ? ovl0 : ovl1) begin
                lat = c;
                break;
            end
        end
        if (lat < 0) return;
        prod = use0 ? msg0 : msg1;
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
    endtask

    logic [31:0] tab_a [7] = '{32'd3, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'h80000000, 32'h80000000, 32'h1234, 32'hFFFFFFFF};
    logic [31:0] tab_b [7] = '{32'd4, 32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h0, 32'hFFFFFFFF};
    logic        tab_s [7] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [63:0] tab_p [7] = '{64'hC, 64'hFFFFFFFFFFFFFFF1, 64'h00000004FFFFFFF1, 64'h4000000000000000,
                               64'h4000000000000000, 64'h0, 64'hFFFFFFFE00000001};

    task automatic test_reset();
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (ovl1 !== 1'b0) begin errors++; $display("FAIL reset_oval: got %b want 0", ovl1); end
        checks++; if (msg1 !== 64'h0) begin errors++; $display("FAIL reset_msg: got %h want 0", msg1); end
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL reset_irdy: got %b want 0", rdy1); end
        reset = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (rdy1 !== 1'b1) begin errors++; $display("FAIL idle_irdy: got %b want 1", rdy1); end
        $display("reset: oval=%b msg=%h irdy=%b", ovl1, msg1, rdy1);
    endtask

    task automatic test_directed();
        logic [63:0] p;
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(1'b0, tab_a[i], tab_b[i], tab_s[i], p, lat);
            $display("early: %h*%h s=%b -> %h k=%0d", tab_a[i], tab_b[i], tab_s[i], p, lat);
            checks++; if (p !== tab_p[i]) begin errors++; $display("FAIL early_prod[%0d]: got %h want %h", i, p, tab_p[i]); end
            checks++; if (lat != ref_k(tab_b[i], tab_s[i], 1'b1)) begin errors++;
                $display("FAIL early_lat[%0d]: got %0d want %0d", i, lat, ref_k(tab_b[i], tab_s[i], 1'b1)); end
        end
    endtask

    task automatic test_no_early_exit();
        logic [63:0] p;
        int lat;
        for (int i = 0; i < 7; i++) begin
            do_op(1'b1, tab_a[i], tab_b[i], tab_s[i], p, lat);
            $display("full: %h*%h s=%b -> %h k=%0d", tab_a[i], tab_b[i], tab_s[i], p, lat);
            checks++; if (p !== tab_p[i]) begin errors++; $display("FAIL full_prod[%0d]: got %h want %h", i, p, tab_p[i]); end
            checks++; if (lat != 32) begin errors++; $display("FAIL full_lat[%0d]: got %0d want 32", i, lat); end
        end
    endtask

    task automatic test_stall();
        logic [63:0] held, p;
        int n;
        bit seen;
        a = 32'd9; b = 32'd11; s = 1'b0;
        n = 0;
        while (!rdy1 && n < 100) begin @(posedge clk); #1; n++; end
        val1 = 1'b1;
        @(posedge clk); #1;
        val1 = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin @(posedge clk); #1; seen = ovl1; end
        checks++; if (!seen) begin errors++; $display("FAIL stall_timeout: got no response want one"); end
        held = msg1;
        checks++; if (held !== 64'd99) begin errors++; $display("FAIL stall_prod: got %h want %h", held, 64'd99); end
        a = 32'd7; b = 32'd3; val1 = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            checks++; if (msg1 !== held || ovl1 !== 1'b1) begin errors++;
                $display("FAIL stall_hold[%0d]: got val=%b msg=%h want val=1 msg=%h", c, ovl1, msg1, held); end
            checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL stall_irdy[%0d]: got %b want 0", c, rdy1); end
        end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        checks++; if (ovl1 !== 1'b0 || rdy1 !== 1'b1) begin errors++;
            $display("FAIL resp_fire: got oval=%b irdy=%b want oval=0 irdy=1", ovl1, rdy1); end
        @(posedge clk); #1;
        val1 = 1'b0;
        checks++; if (rdy1 !== 1'b0) begin errors++; $display("FAIL next_accept: got irdy=%b want 0", rdy1); end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin @(posedge clk); #1; seen = ovl1; end
        p = msg1;
        checks++; if (p !== 64'd21) begin errors++; $display("FAIL stall_next_prod: got %h want %h", p, 64'd21); end
        ordy = 1'b1;
        @(posedge clk); #1;
        ordy = 1'b0;
        $display("stall: held=%h next=%h", held, p);
    endtask

    task automatic test_reset_mid();
        logic [63:0] p;
        int lat, n;
        bit spurious;
        a = 32'h1234; b = 32'hFFFF; s = 1'b0;
        n = 0;
        while (!rdy1 && n < 100) begin @(posedge clk); #1; n++; end
        val1 = 1'b1;
        @(posedge clk); #1;
        val1 = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        checks++; if (ovl1 !== 1'b0 || rdy1 !== 1'b0) begin errors++;
            $display("FAIL mid_reset: got oval=%b irdy=%b want 0 0", ovl1, rdy1); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        spurious = 1'b0;
        repeat (20) begin @(posedge clk); #1; if (ovl1) spurious = 1'b1; end
        checks++; if (spurious) begin errors++; $display("FAIL spurious_resp: got response want none"); end
        do_op(1'b0, 32'd7, 32'd6, 1'b0, p, lat);
        $display("after reset: 7*6 -> %0d k=%0d", p, lat);
        checks++; if (p !== 64'd42) begin errors++; $display("FAIL post_reset_prod: got %0d want 42", p); end
        checks++; if (lat != 3) begin errors++; $display("FAIL post_reset_lat: got %0d want 3", lat); end
    endtask

    task automatic test_random();
        localparam int N = 40;
        logic [63:0] expq[$];
        int got;
        fork
            begin : producer
                logic [31:0] ra, rb;
                logic rs;
                int n;
                for (int i = 0; i < N; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
                    ra = $urandom;
                    rb = $urandom;
                    rs = 1'($urandom_range(0, 1));
                    if ($urandom_range(0, 3) == 0) rb = rb & 32'hFF;
                    a = ra; b = rb; s = rs; val1 = 1'b1;
                    n = 0;
                    while (!rdy1 && n < 200) begin @(posedge clk); #1; n++; end
                    @(posedge clk); #1;
                    val1 = 1'b0;
                    expq.push_back(ref_prod(ra, rb, rs));
                end
            end
            begin : consumer
                logic [63:0] e;
                int cyc;
                got = 0;
                cyc = 0;
                while (got < N && cyc < 20000) begin
                    ordy = 1'($urandom_range(0, 1));
                    if (ovl1 && ordy) begin
                        checks++;
                        if (expq.size() == 0) begin
                            errors++;
                            $display("FAIL rand_extra[%0d]: got %h want no response", got, msg1);
                        end else begin
                            e = expq.pop_front();
                            if (msg1 !== e) begin errors++; $display("FAIL rand_prod[%0d]: got %h want %h", got, msg1, e); end
                            else $display("rand %0d: product %h", got, msg1);
                        end
                        got++;
                    end
                    @(posedge clk); #1;
                    cyc++;
                end
                ordy = 1'b0;
            end
        join
        checks++; if (got != N) begin errors++; $display("FAIL rand_count: got %0d want %0d", got, N); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_no_early_exit();
        test_stall();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
